// File: rtl/prbs_bit_source.sv
// rtl/prbs_bit_source.sv - selectable-polynomial PRBS bit source; define PRBS_ERR_INJECT_EN for single-bit error injection
module prbs_bit_source #(
    parameter int PERIOD_W = 32
) (
    input  logic                dac_clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [2:0]          poly_sel,
    input  logic [30:0]         seed,
    input  logic                seed_load,
    input  logic [PERIOD_W-1:0] bit_period,
    input  logic                inject_err,
    output logic                prbs_bit_out,
    output logic                bit_strobe,
    output logic                seq_sync,
    output logic                running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);

    state_t              state;
    state_t              state_next;
    logic [2:0]          poly_q;
    logic [30:0]         lfsr;
    logic [30:0]         seed_q;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] cnt_term;
    logic [4:0]          n_load;
    logic [4:0]          n_run;
    logic [4:0]          t_run;
    logic [30:0]         mask_load;
    logic [30:0]         mask_run;
    logic [30:0]         seed_masked;
    logic [30:0]         seed_eff;
    logic [30:0]         lfsr_next;
    logic                fb;
    logic                advance;
    logic                err_pend;

    // Register length N for a polynomial select; unused codes fall back to PRBS7.
    function automatic logic [4:0] poly_len(input logic [2:0] p);
        case (p)
            3'd1:    return 5'd9;
            3'd2:    return 5'd15;
            3'd3:    return 5'd23;
            3'd4:    return 5'd31;
            default: return 5'd7;
        endcase
    endfunction

    // Second feedback tap T for a polynomial select.
    function automatic logic [4:0] poly_tap(input logic [2:0] p);
        case (p)
            3'd1:    return 5'd5;
            3'd2:    return 5'd14;
            3'd3:    return 5'd18;
            3'd4:    return 5'd28;
            default: return 5'd6;
        endcase
    endfunction

    // Low-N-bits mask so every register bit above the active length stays zero.
    function automatic logic [30:0] len_mask(input logic [4:0] n);
        logic [31:0] m;
        m = (32'd1 << n) - 32'd1;
        return m[30:0];
    endfunction

    assign n_load      = poly_len(poly_sel);
    assign mask_load   = len_mask(n_load);
    assign seed_masked = seed & mask_load;
    // An all-zero seed would lock the LFSR, so substitute all-ones.
    assign seed_eff    = (seed_masked == '0) ? mask_load : seed_masked;

    assign n_run     = poly_len(poly_q);
    assign t_run     = poly_tap(poly_q);
    assign mask_run  = len_mask(n_run);
    assign fb        = lfsr[n_run - 5'd1] ^ lfsr[t_run - 5'd1];
    assign lfsr_next = {lfsr[29:0], fb} & mask_run;

    // A zero period behaves as one cycle per bit.
    assign cnt_term = (bit_period == '0) ? '0 : (bit_period - CNT_ONE);
    assign advance  = (state == RUN) && (cnt == cnt_term);
    assign running  = (state == RUN);

    // State register.
    always_ff @(posedge dac_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; dropping enable takes priority over a reload request.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = RUN;
            end
            RUN: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (seed_load) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // LFSR, bit-period counter and registered outputs; the output bit holds outside advances.
    always_ff @(posedge dac_clk or negedge reset_n) begin
        if (!reset_n) begin
            poly_q       <= 3'd0;
            lfsr         <= '1;
            seed_q       <= '1;
            cnt          <= '0;
            prbs_bit_out <= 1'b0;
            bit_strobe   <= 1'b0;
            seq_sync     <= 1'b0;
        end else begin
            bit_strobe <= 1'b0;
            seq_sync   <= 1'b0;
            case (state)
                LOAD: begin
                    poly_q <= poly_sel;
                    lfsr   <= seed_eff;
                    seed_q <= seed_eff;
                    cnt    <= '0;
                end
                RUN: begin
                    if (advance) begin
                        lfsr         <= lfsr_next;
                        prbs_bit_out <= fb ^ err_pend;
                        bit_strobe   <= 1'b1;
                        seq_sync     <= (lfsr_next == seed_q);
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PRBS_ERR_INJECT_EN
    // Pending-error flag: a pulse coinciding with an advance is kept for the following bit.
    always_ff @(posedge dac_clk or negedge reset_n) begin
        if (!reset_n) begin
            err_pend <= 1'b0;
        end else if (state == LOAD) begin
            err_pend <= 1'b0;
        end else if (advance) begin
            err_pend <= inject_err;
        end else if (inject_err) begin
            err_pend <= 1'b1;
        end
    end
`else
    logic unused_inject_err;
    assign unused_inject_err = inject_err;
    assign err_pend          = 1'b0;
`endif

endmodule

// File: tb/tb_prbs_bit_source.sv
// tb/tb_prbs_bit_source.sv - self-checking bench for prbs_bit_source
`timescale 1ns/1ps
module tb_prbs_bit_source;

    logic        dac_clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [2:0]  poly_sel;
    logic [30:0] seed;
    logic        seed_load;
    logic [31:0] bit_period;
    logic        inject_err;
    logic        prbs_bit_out;
    logic        bit_strobe;
    logic        seq_sync;
    logic        running;

    prbs_bit_source #(.PERIOD_W(32)) dut (
        .dac_clk      (dac_clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .poly_sel     (poly_sel),
        .seed         (seed),
        .seed_load    (seed_load),
        .bit_period   (bit_period),
        .inject_err   (inject_err),
        .prbs_bit_out (prbs_bit_out),
        .bit_strobe   (bit_strobe),
        .seq_sync     (seq_sync),
        .running      (running)
    );

    always #5 dac_clk = ~dac_clk;

    int checks = 0;
    int errors = 0;
    bit exp_out = 1'b0;
    bit dut_bits[$];
    int sync_idx[$];
    bit win[$];
    bit init_win[$];
    int mn;
    int mt;

    typedef struct {
        logic [2:0]  poly;
        logic [30:0] sd;
        int          per;
        bit          first;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the bit stream as a recurrence b[k] = b[k-N] ^ b[k-T] over a history window.
    function automatic void model_init(input logic [2:0] p, input logic [30:0] s);
        bit all_zero;
        case (p)
            3'd1:    begin mn = 9;  mt = 5;  end
            3'd2:    begin mn = 15; mt = 14; end
            3'd3:    begin mn = 23; mt = 18; end
            3'd4:    begin mn = 31; mt = 28; end
            default: begin mn = 7;  mt = 6;  end
        endcase
        all_zero = 1'b1;
        for (int i = 0; i < mn; i++) if (s[i]) all_zero = 1'b0;
        win.delete();
        for (int i = 0; i < mn; i++) win.push_back(all_zero ? 1'b1 : s[mn-1-i]);
        init_win = win;
    endfunction

    function automatic void model_next(output bit b, output bit sy);
        b = win[0] ^ win[mn-mt];
        win.push_back(b);
        void'(win.pop_front());
        sy = 1'b1;
        for (int i = 0; i < mn; i++) if (win[i] != init_win[i]) sy = 1'b0;
    endfunction

    task automatic run_stream(input logic [2:0] poly, input logic [30:0] sd, input int per,
                              input int nbits, input int inj_k, input bit use_load,
                              input bit stop, input int hold, input bit scramble);
        int p;
        int total;
        int nseen;
        bit b;
        bit sy;
        bit inv;
        bit exp_strobe;
        bit exp_sync;
        p = (per == 0) ? 1 : per;
        total = 2 + p * nbits;
        nseen = 0;
        model_init(poly, sd);
        dut_bits.delete();
        sync_idx.delete();
        poly_sel = poly;
        seed = sd;
        bit_period = per;
        if (use_load) seed_load = 1'b1;
        else enable = 1'b1;
        for (int t = 1; t <= total; t++) begin
            @(posedge dac_clk); #1;
            seed_load = 1'b0;
            inject_err = 1'b0;
            exp_strobe = (t >= 2 + p) && (((t - 2) % p) == 0);
            exp_sync = 1'b0;
            if (exp_strobe) begin
                model_next(b, sy);
                nseen++;
                inv = 1'b0;
`ifdef PRBS_ERR_INJECT_EN
                inv = (nseen == inj_k);
`endif
                exp_out = b ^ inv;
                exp_sync = sy;
                dut_bits.push_back(prbs_bit_out);
                if (seq_sync) sync_idx.push_back(nseen);
            end
            chk("running", running, 32'(t >= 2));
            chk("bit_strobe", bit_strobe, 32'(exp_strobe));
            chk("seq_sync", seq_sync, 32'(exp_sync));
            chk("prbs_bit_out", prbs_bit_out, 32'(exp_out));
            if (scramble && t == 2) begin
                poly_sel = 3'($urandom);
                seed = 31'($urandom);
            end
            if (inj_k >= 2 && t >= 1 + p * (inj_k - 1) && t <= p * inj_k) inject_err = 1'b1;
        end
        if (stop) begin
            enable = 1'b0;
            @(posedge dac_clk); #1;
            exp_sync = 1'b0;
            if (p == 1) begin
                model_next(b, sy);
                exp_out = b;
                exp_sync = sy;
            end
            chk("stop_strobe", bit_strobe, 32'(p == 1));
            chk("stop_sync", seq_sync, 32'(exp_sync));
            chk("stop_running", running, 32'd0);
            chk("stop_out", prbs_bit_out, 32'(exp_out));
            for (int h = 0; h < hold; h++) begin
                @(posedge dac_clk); #1;
                chk("hold_strobe", bit_strobe, 32'd0);
                chk("hold_sync", seq_sync, 32'd0);
                chk("hold_running", running, 32'd0);
                chk("hold_out", prbs_bit_out, 32'(exp_out));
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] got7;
        logic [6:0] want7;

        tbl[0] = '{3'd0, 31'h0000007F, 1, 1'b0};
        tbl[1] = '{3'd1, 31'h00000001, 5, 1'b0};
        tbl[2] = '{3'd2, 31'h00004000, 0, 1'b1};
        tbl[3] = '{3'd3, 31'h00000000, 3, 1'b0};
        tbl[4] = '{3'd4, 31'h08000000, 2, 1'b1};
        tbl[5] = '{3'd5, 31'h00000180, 1, 1'b0};
        tbl[6] = '{3'd7, 31'h7FFFFF20, 1, 1'b1};

        reset_n = 1'b0;
        enable = 1'b0;
        poly_sel = 3'd0;
        seed = '0;
        seed_load = 1'b0;
        bit_period = 32'd1;
        inject_err = 1'b0;
        repeat (3) @(posedge dac_clk);
        #1;
        chk("rst_out", prbs_bit_out, 32'd0);
        chk("rst_strobe", bit_strobe, 32'd0);
        chk("rst_sync", seq_sync, 32'd0);
        chk("rst_running", running, 32'd0);
        @(negedge dac_clk);
        reset_n = 1'b1;
        @(negedge dac_clk);

        // PRBS7 from 0x7F: known first bits and sync every 127 bits.
        run_stream(3'd0, 31'h7F, 1, 260, 0, 1'b0, 1'b1, 3, 1'b1);
        for (int i = 0; i < 7; i++) got7[6-i] = dut_bits[i];
        chk("prbs7_first7", 32'(got7), 32'h01);
        chk("prbs7_sync_count", sync_idx.size(), 32'd2);
        chk("prbs7_sync1", (sync_idx.size() > 0) ? sync_idx[0] : -1, 32'd127);
        chk("prbs7_sync2", (sync_idx.size() > 1) ? sync_idx[1] : -1, 32'd254);

        // Table: every polynomial select, zero seeds and zero period.
        for (int i = 0; i < 7; i++) begin
            run_stream(tbl[i].poly, tbl[i].sd, tbl[i].per, 30, 0, 1'b0, 1'b1, 3, 1'b1);
            chk("tbl_first_bit", 32'(dut_bits[0]), 32'(tbl[i].first));
        end

        // PRBS31 from a zero seed against the model.
        run_stream(3'd4, 31'h0, 1, 30000, 0, 1'b0, 1'b1, 2, 1'b1);

        // PRBS9 period 5, enable dropped 20 cycles, then restart from seed.
        run_stream(3'd1, 31'h1A5, 5, 20, 0, 1'b0, 1'b1, 20, 1'b0);
        run_stream(3'd1, 31'h1A5, 5, 20, 0, 1'b0, 1'b1, 3, 1'b0);

        // seed_load in RUN restarts the sequence; then seed_load with enable low.
        run_stream(3'd2, 31'h1234, 4, 10, 0, 1'b0, 1'b0, 0, 1'b1);
        run_stream(3'd3, 31'h5A5A5A, 3, 12, 0, 1'b1, 1'b0, 0, 1'b1);
        enable = 1'b0;
        seed_load = 1'b1;
        @(posedge dac_clk); #1;
        seed_load = 1'b0;
        chk("sl_dis_running", running, 32'd0);
        chk("sl_dis_strobe", bit_strobe, 32'd0);
        chk("sl_dis_out", prbs_bit_out, 32'(exp_out));
        repeat (4) begin
            @(posedge dac_clk); #1;
            chk("sl_dis_running_hold", running, 32'd0);
            chk("sl_dis_out_hold", prbs_bit_out, 32'(exp_out));
        end

        // Error injection before bit 3 of PRBS7.
        run_stream(3'd0, 31'h7F, 1, 260, 3, 1'b0, 1'b1, 3, 1'b0);
        for (int i = 0; i < 7; i++) got7[6-i] = dut_bits[i];
`ifdef PRBS_ERR_INJECT_EN
        want7 = 7'b0010001;
`else
        want7 = 7'b0000001;
`endif
        chk("inject_first7", 32'(got7), 32'(want7));
        chk("inject_sync1", (sync_idx.size() > 0) ? sync_idx[0] : -1, 32'd127);

        // Randomized streams.
        for (int r = 0; r < 6; r++) begin
            run_stream(3'($urandom_range(0, 7)), 31'($urandom), int'($urandom_range(0, 6)), 50,
                       int'($urandom_range(2, 20)), 1'b0, 1'b1, 3, 1'b1);
        end

        // Asynchronous reset mid-run.
        run_stream(3'd0, 31'h7F, 1, 7, 0, 1'b0, 1'b0, 0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out", prbs_bit_out, 32'd0);
        chk("arst_strobe", bit_strobe, 32'd0);
        chk("arst_sync", seq_sync, 32'd0);
        chk("arst_running", running, 32'd0);
        enable = 1'b0;
        @(negedge dac_clk);
        reset_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
